mc_ctrl_fsm: RTL and testbench

- Multicycle main controller for the MIPS-subset CPU.
- Sequences instruction fetch, decode, execute, memory and writeback, and drives the ALU controls (alu_src, alu_op) plus all datapath enables.
- Handles the memory ready handshake, the addi overflow trap, illegal opcodes and halt.
- Sits between the instruction register and the datapath (PC, IR, register file, ALU, data memory).

---
 rtl/mc_ctrl_fsm_pkg.sv | 57 +++++
 rtl/mc_ctrl_fsm_if.sv | 47 ++++
 rtl/mc_instr_decode.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants for the multicycle main controller.
// Opcodes, func codes, state and instruction-class encodings.
package mc_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;

    // S_HALT_TO is the halt entered through the watchdog;
    // it keeps mem_timeout sticky without extra storage.
    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_IF      = 4'd1,
        S_ID      = 4'd2,
        S_EXE     = 4'd3,
        S_MEM     = 4'd4,
        S_WB      = 4'd5,
        S_WBL     = 4'd6,
        S_BR      = 4'd7,
        S_HALT    = 4'd8,
        S_HALT_TO = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_ILL   = 4'd0,
        C_RTYPE = 4'd1,
        C_ORI   = 4'd2,
        C_ADDI  = 4'd3,
        C_ADDIU = 4'd4,
        C_LUI   = 4'd5,
        C_LW    = 4'd6,
        C_SW    = 4'd7,
        C_BEQ   = 4'd8,
        C_J     = 4'd9,
        C_HALT  = 4'd10
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle.
// master = controller, slave = datapath.
interface mc_ctrl_fsm_if;

    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       overflow;
    logic       mem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       halted;
    logic       illegal_op;
    logic       ovf_trap;
    logic       mem_timeout;
    logic       instr_done;

    modport master (
        input  opcode, func, zero, overflow, mem_ready,
        output pc_write, pc_src, ir_write, iord,
        output mem_read, mem_write, reg_write,
        output reg_dst, mem_to_reg, alu_src, alu_op,
        output ext_op, halted, illegal_op, ovf_trap,
        output mem_timeout, instr_done
    );

    modport slave (
        output opcode, func, zero, overflow, mem_ready,
        input  pc_write, pc_src, ir_write, iord,
        input  mem_read, mem_write, reg_write,
        input  reg_dst, mem_to_reg, alu_src, alu_op,
        input  ext_op, halted, illegal_op, ovf_trap,
        input  mem_timeout, instr_done
    );

endinterface

// File: rtl/mc_instr_decode.sv
// Opcode/func to instruction class.
// Purely combinational; IR is stable after fetch.
import mc_ctrl_fsm_pkg::*;

module mc_instr_decode (
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic       legal
);

    // Classify the instruction held in IR
    always_comb begin
        iclass = C_ILL;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                if (func == FN_ADDU || func == FN_SUBU ||
                    func == FN_SLT)
                    iclass = C_RTYPE;
            end
            opcode == OP_ORI:   iclass = C_ORI;
            opcode == OP_ADDI:  iclass = C_ADDI;
            opcode == OP_ADDIU: iclass = C_ADDIU;
            opcode == OP_LUI:   iclass = C_LUI;
            opcode == OP_LW:    iclass = C_LW;
            opcode == OP_SW:    iclass = C_SW;
            opcode == OP_BEQ:   iclass = C_BEQ;
            opcode == OP_J:     iclass = C_J;
            opcode == OP_HALT:  iclass = C_HALT;
            default:            iclass = C_ILL;
        endcase
        legal = (iclass != C_ILL);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: IF/ID/EXE/MEM/WB sequencing,
// memory wait handling with watchdog, traps and halt.
import mc_ctrl_fsm_pkg::*;

module mc_ctrl_fsm #(
    parameter int WAIT_LIMIT = 16
) (
    input logic          clk,
    input logic          rst_n,
    mc_ctrl_fsm_if.master bus
);

    localparam int WDW =
        (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST =
        WDW'(WAIT_LIMIT - 1);
    localparam bit WD_ON = (WAIT_LIMIT != 0);

    state_t         state;
    logic [WDW-1:0] wd_cnt;
    iclass_t        iclass;
    logic           legal;
    logic           waiting;
    logic           wd_hit;
    logic           alu_hold;

    mc_instr_decode u_dec (
        .opcode (bus.opcode),
        .func   (bus.func),
        .iclass (iclass),
        .legal  (legal)
    );

    assign waiting = (state == S_IF || state == S_MEM) &&
                     !bus.mem_ready;
    assign wd_hit  = WD_ON && waiting && (wd_cnt == WD_LAST);

    // State register and consecutive-wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_INIT;
            wd_cnt <= '0;
        end else begin
            if (WD_ON && waiting && !wd_hit)
                wd_cnt <= wd_cnt + WDW'(1);
            else
                wd_cnt <= '0;
            unique case (state)
                S_INIT: state <= S_IF;
                S_IF: begin
                    if (bus.mem_ready)
                        state <= S_ID;
                    else if (wd_hit)
                        state <= S_HALT_TO;
                end
                S_ID: begin
                    unique case (iclass)
                        C_BEQ:   state <= S_BR;
                        C_J:     state <= S_IF;
                        C_HALT:  state <= S_HALT;
                        C_ILL:   state <= S_IF;
                        default: state <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    if (iclass == C_LW || iclass == C_SW)
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (bus.mem_ready)
                        state <= (iclass == C_LW) ? S_WBL : S_IF;
                    else if (wd_hit)
                        state <= S_HALT_TO;
                end
                S_WB:      state <= S_IF;
                S_WBL:     state <= S_IF;
                S_BR:      state <= S_IF;
                S_HALT:    state <= S_HALT;
                S_HALT_TO: state <= S_HALT_TO;
                default:   state <= S_INIT;
            endcase
        end
    end

    assign alu_hold = (state == S_EXE) || (state == S_MEM) ||
                      (state == S_WB)  || (state == S_WBL);

    // Output decode from state, qualified by handshake/flags
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.pc_src      = PC_SEQ;
        bus.ir_write    = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src     = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.ext_op      = 1'b0;
        bus.halted      = 1'b0;
        bus.illegal_op  = 1'b0;
        bus.ovf_trap    = 1'b0;
        bus.mem_timeout = 1'b0;
        bus.instr_done  = 1'b0;

        if (alu_hold) begin
            unique case (iclass)
                C_RTYPE: begin
                    bus.alu_op  = ALU_SUB;
                end
                C_ORI: begin
                    bus.alu_src = 1'b1;
                    bus.alu_op  = ALU_OR;
                end
                C_ADDI, C_ADDIU, C_LW, C_SW: begin
                    bus.alu_src = 1'b1;
                    bus.ext_op  = 1'b1;
                end
                C_LUI: begin
                    bus.alu_src = 1'b1;
                end
                default: ;
            endcase
        end

        unique case (state)
            S_IF: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            S_ID: begin
                if (iclass == C_J) begin
                    bus.pc_write   = 1'b1;
                    bus.pc_src     = PC_JMP;
                    bus.instr_done = 1'b1;
                end
                if (!legal) begin
                    bus.illegal_op = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            S_MEM: begin
                bus.iord       = 1'b1;
                bus.mem_read   = (iclass == C_LW);
                bus.mem_write  = (iclass == C_SW);
                bus.instr_done = (iclass == C_SW) && bus.mem_ready;
            end
            S_WB: begin
                bus.ovf_trap   = (iclass == C_ADDI) && bus.overflow;
                bus.reg_write  = !((iclass == C_ADDI) && bus.overflow);
                bus.reg_dst    = (iclass == C_RTYPE);
                bus.instr_done = 1'b1;
            end
            S_WBL: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BR: begin
                bus.alu_op     = ALU_SUB;
                bus.ext_op     = 1'b1;
                bus.pc_write   = bus.zero;
                bus.pc_src     = PC_BR;
                bus.instr_done = 1'b1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            S_HALT_TO: begin
                bus.halted      = 1'b1;
                bus.mem_timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm.
// Per-instruction totals compared against instruction-level rules.
module tb_mc_ctrl_fsm;

    localparam int K_ADDU  = 0;
    localparam int K_SUBU  = 1;
    localparam int K_SLT   = 2;
    localparam int K_ORI   = 3;
    localparam int K_ADDI  = 4;
    localparam int K_ADDIU = 5;
    localparam int K_LUI   = 6;
    localparam int K_LW    = 7;
    localparam int K_SW    = 8;
    localparam int K_BEQ   = 9;
    localparam int K_J     = 10;
    localparam int K_ILL   = 11;

    logic [5:0] op_tab [0:10] = '{
        6'h00, 6'h00, 6'h00, 6'h0d, 6'h08, 6'h09,
        6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02
    };
    logic [5:0] fn_tab [0:2] = '{6'h21, 6'h23, 6'h2a};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.WAIT_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [19:0] outs();
        return {bus.pc_write, bus.pc_src, bus.ir_write,
                bus.iord, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src, bus.alu_op, bus.ext_op,
                bus.halted, bus.illegal_op, bus.ovf_trap,
                bus.mem_timeout, bus.instr_done};
    endfunction

    function automatic bit is_legal(input logic [5:0] op,
                                    input logic [5:0] fn);
        if (op == 6'h00)
            return fn == 6'h21 || fn == 6'h23 || fn == 6'h2a;
        return op inside {6'h0d, 6'h08, 6'h09, 6'h0f, 6'h23,
                          6'h2b, 6'h04, 6'h02, 6'h3f};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called positioned #1 into an IF cycle; returns in next IF.
    task automatic run_instr(input int k, input int w_if,
                             input int w_mem, input logic z,
                             input logic ov,
                             input logic [5:0] ill_op);
        logic [5:0] op, fn;
        int acc, wcnt, need, cyc;
        int c_pcw, c_regw, c_rd, c_wr, c_ir, c_ill, c_ovf;
        int c_iord, c_conf;
        int e_cyc, e_pcw, e_regw, e_rd, e_wr;
        bit rtype, imm, mem;
        logic done;
        logic [1:0] last_src, e_src;
        logic [1:0] wsel;
        logic [3:0] alu_done, e_alu;
        bit chk_alu;
        string t;

        fn = 6'($urandom);
        if (k == K_ILL) begin
            op = ill_op;
            if (op == 6'h00) begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (is_legal(op, fn));
            end
        end else begin
            op = op_tab[k];
            if (k <= K_SLT) fn = fn_tab[k];
        end
        bus.opcode = op;
        bus.func = fn;
        bus.zero = z;
        bus.overflow = ov;

        acc = 0; wcnt = 0; cyc = 0; done = 1'b0;
        c_pcw = 0; c_regw = 0; c_rd = 0; c_wr = 0; c_ir = 0;
        c_ill = 0; c_ovf = 0; c_iord = 0; c_conf = 0;
        last_src = 2'b11; wsel = 2'b11; alu_done = 4'hf;
        while (!done && cyc < 40) begin
            if (bus.mem_read || bus.mem_write) begin
                need = (acc == 0) ? w_if : w_mem;
                if (wcnt < need) begin
                    bus.mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    bus.mem_ready = 1'b1;
                    acc++;
                    wcnt = 0;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            c_pcw  += int'(bus.pc_write);
            c_regw += int'(bus.reg_write);
            c_rd   += int'(bus.mem_read);
            c_wr   += int'(bus.mem_write);
            c_ir   += int'(bus.ir_write);
            c_ill  += int'(bus.illegal_op);
            c_ovf  += int'(bus.ovf_trap);
            c_iord += int'(bus.iord);
            if (bus.pc_write &&
                (bus.iord || bus.mem_write || bus.reg_write))
                c_conf++;
            if (bus.pc_write) last_src = bus.pc_src;
            if (bus.reg_write)
                wsel = {bus.reg_dst, bus.mem_to_reg};
            if (bus.instr_done) begin
                done = 1'b1;
                alu_done = {bus.alu_src, bus.alu_op, bus.ext_op};
            end
            @(posedge clk);
            #1;
        end

        rtype = (k <= K_SLT);
        imm   = (k >= K_ORI && k <= K_LUI);
        mem   = (k == K_LW || k == K_SW);
        if (rtype || imm) e_cyc = 4;
        else if (k == K_LW) e_cyc = 5;
        else if (k == K_SW) e_cyc = 4;
        else if (k == K_BEQ) e_cyc = 3;
        else e_cyc = 2;
        e_cyc += w_if + (mem ? w_mem : 0);
        e_pcw = 1 + ((k == K_J) ? 1 : 0) +
                ((k == K_BEQ && z) ? 1 : 0);
        e_regw = (rtype || k == K_ORI || k == K_ADDIU ||
                  k == K_LUI || k == K_LW ||
                  (k == K_ADDI && !ov)) ? 1 : 0;
        e_rd = w_if + 1 + ((k == K_LW) ? w_mem + 1 : 0);
        e_wr = (k == K_SW) ? w_mem + 1 : 0;
        e_src = (k == K_J) ? 2'b10 :
                (k == K_BEQ && z) ? 2'b01 : 2'b00;

        t = $sformatf("k%0d op%0h", k, op);
        check({t, " done"}, 32'(done), 1);
        check({t, " cycles"}, cyc, e_cyc);
        check({t, " pc_write"}, c_pcw, e_pcw);
        check({t, " pc_src"}, 32'(last_src), 32'(e_src));
        check({t, " ir_write"}, c_ir, 1);
        check({t, " reg_write"}, c_regw, e_regw);
        check({t, " mem_read"}, c_rd, e_rd);
        check({t, " mem_write"}, c_wr, e_wr);
        check({t, " iord"}, c_iord, mem ? w_mem + 1 : 0);
        check({t, " illegal"}, c_ill, (k == K_ILL) ? 1 : 0);
        check({t, " ovf_trap"}, c_ovf,
              (k == K_ADDI && ov) ? 1 : 0);
        check({t, " conflict"}, c_conf, 0);
        if (e_regw != 0)
            check({t, " dst_m2r"}, 32'(wsel),
                  rtype ? 2 : (k == K_LW) ? 1 : 0);

        chk_alu = 1'b1;
        e_alu = 4'h0;
        if (rtype) e_alu = 4'b0010;
        else if (k == K_ORI) e_alu = 4'b1100;
        else if (k == K_ADDI || k == K_ADDIU || k == K_SW)
            e_alu = 4'b1001;
        else if (k == K_LUI) e_alu = 4'b1000;
        else if (k == K_BEQ) e_alu = 4'b0011;
        else chk_alu = 1'b0;
        if (rtype) alu_done[0] = 1'b0;
        if (chk_alu)
            check({t, " alu"}, 32'(alu_done), 32'(e_alu));
    endtask

    initial begin
        int n;
        int k;
        bus.opcode = 6'h00;
        bus.func = 6'h21;
        bus.zero = 1'b0;
        bus.overflow = 1'b0;
        bus.mem_ready = 1'b1;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_if_mem_read", 32'(bus.mem_read), 1);
        check("reset_if_iord", 32'(bus.iord), 0);

        run_instr(K_ADDU, 0, 0, 1'b0, 1'b0, 6'h00);
        run_instr(K_LW,   0, 3, 1'b0, 1'b0, 6'h00);
        run_instr(K_BEQ,  0, 0, 1'b1, 1'b0, 6'h00);
        run_instr(K_BEQ,  0, 0, 1'b0, 1'b0, 6'h00);
        run_instr(K_ADDI, 0, 0, 1'b0, 1'b1, 6'h00);
        run_instr(K_ILL,  0, 0, 1'b0, 1'b0, 6'h15);
        run_instr(K_SW,   3, 3, 1'b0, 1'b0, 6'h00);
        run_instr(K_J,    1, 0, 1'b0, 1'b0, 6'h00);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 11);
            run_instr(k,
                      ($urandom_range(0, 1) == 0) ? 0 :
                          $urandom_range(1, 3),
                      $urandom_range(0, 3),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 6'h00);
        end

        // Watchdog: mem_ready stuck low in IF
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 20 && !bus.halted; i++) begin
            n += int'(bus.mem_read);
            @(posedge clk);
            #1;
        end
        check("to_if_cycles", n, 4);
        check("to_timeout", 32'(bus.mem_timeout), 1);
        check("to_halted", 32'(bus.halted), 1);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("to_sticky",
                  32'({bus.mem_timeout, bus.halted,
                       bus.mem_read, bus.pc_write}), 4'b1100);
        end

        // Halt opcode
        bus.opcode = 6'h3f;
        do_reset();
        bus.mem_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && !bus.halted; i++) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("halt_cycles", n, 2);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("halt_state",
                  32'({bus.pc_write, bus.ir_write, bus.mem_read,
                       bus.mem_write, bus.reg_write, bus.halted,
                       bus.mem_timeout, bus.instr_done}),
                  8'b00000100);
        end

        // Reset in the middle of a stalled lw access
        bus.opcode = 6'h23;
        do_reset();
        n = 0;
        for (int i = 0; i < 10 && !bus.iord; i++) begin
            bus.mem_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        #1;
        check("mid_mem_iord", 32'({bus.iord, bus.mem_read}), 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_mem_reset", 32'(outs()), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_mem_refetch",
              32'({bus.mem_read, bus.iord}), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
